// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART program/data loader.
package uart_pkg;

  // Bit-level receiver states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int BYTE_W = 8;

  // Number of bytes that make up one word of the given width
  function automatic int bytes_per_word(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Running XOR checksum over payload bytes
  function automatic logic [7:0] checksum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with 2-flop synchroniser, power-up arming
// and mid-bit start validation. byte_valid fires the cycle after the stop bit
// is sampled high; frame_err_pulse is asserted in the stop-sample cycle itself
// so the loader can register a sticky flag one cycle later.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  logic             rx_meta;
  logic             rx_sync;
  logic [1:0]       sync_fill;
  logic             armed;
  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             cnt_clr;
  logic             bit_sample;
  logic             stop_sample;

  // Two-flop synchroniser for the asynchronous line, idle-high after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Arm only once a real (non-reset-value) high sample has passed the synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_sync) begin
        armed <= 1'b1;
      end
    end
  end

  // Bit FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bit FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (armed && !rx_sync) state_next = START;
        else                   state_next = IDLE;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          if (!rx_sync) state_next = DATA;
          else          state_next = IDLE;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if ((cnt == CNT_LAST) && (bit_idx == 3'd7)) state_next = STOP;
        else                                        state_next = DATA;
      end
      STOP: begin
        if (cnt == CNT_LAST) state_next = IDLE;
        else                 state_next = STOP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit FSM strobes: counter clear and sample points
  always_comb begin
    cnt_clr     = 1'b0;
    bit_sample  = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE:  cnt_clr = 1'b1;
      START: cnt_clr = (cnt == CNT_HALF);
      DATA: begin
        cnt_clr    = (cnt == CNT_LAST);
        bit_sample = (cnt == CNT_LAST);
      end
      STOP: begin
        cnt_clr     = (cnt == CNT_LAST);
        stop_sample = (cnt == CNT_LAST);
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  assign frame_err_pulse = stop_sample && !rx_sync;

  // Bit timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (cnt_clr) cnt <= '0;
      else         cnt <= cnt + CNT_W'(1);
      if (state == IDLE)   bit_idx <= 3'd0;
      else if (bit_sample) bit_idx <= bit_idx + 3'd1;
      if (bit_sample) shift <= {rx_sync, shift[7:1]};
    end
  end

  // Registered byte strobe, byte data and busy indication
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      byte_valid <= stop_sample && rx_sync;
      if (stop_sample && rx_sync) byte_data <= shift;
      busy <= (state_next != IDLE);
    end
  end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: assembles little-endian words from a UART byte stream and
// emits sequential byte-addressed write strobes until DEPTH words are loaded.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module uart_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              busy,
  output logic              frame_err,
  output logic              done,
  output logic              chk_ok
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BPW_A    = ADDR_W'(BPW);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err_pulse;
  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] word_next;
  logic              payload_phase;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .frame_err_pulse (frame_err_pulse),
    .busy            (busy)
  );

  assign payload_phase = (word_cnt != DEPTH_A) && !done;

  // Merge the incoming byte into its little-endian lane of the partial word
  always_comb begin
    word_next = partial;
    word_next[8*byte_idx +: 8] = byte_data;
  end

  // Byte assembler, write strobe and word/address counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      partial  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (byte_valid && payload_phase) begin
        if (byte_idx == IDX_LAST) begin
          wr_en    <= 1'b1;
          wr_data  <= word_next;
          wr_addr  <= word_cnt * BPW_A;
          word_cnt <= word_cnt + ADDR_W'(1);
          byte_idx <= '0;
          partial  <= '0;
        end else begin
          partial  <= word_next;
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end
    end
  end

  // Sticky framing-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (frame_err_pulse) begin
      frame_err <= 1'b1;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_pend;
  logic       chk_match;
  logic       chk_phase;

  assign chk_phase = (word_cnt == DEPTH_A) && !done && !chk_pend;

  // Running XOR over every accepted payload byte
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc <= 8'h00;
    end else if (byte_valid && payload_phase) begin
      chk_acc <= checksum_next(chk_acc, byte_data);
    end
  end

  // Capture the trailing checksum byte and its comparison result
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_pend  <= 1'b0;
      chk_match <= 1'b0;
    end else begin
      chk_pend <= 1'b0;
      if (byte_valid && chk_phase) begin
        chk_pend  <= 1'b1;
        chk_match <= (byte_data == chk_acc);
      end
    end
  end

  // Completion and checksum verdict, registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      chk_ok <= 1'b1;
    end else if (chk_pend) begin
      done   <= 1'b1;
      chk_ok <= chk_match;
    end
  end
`else
  // Completion follows the final word; no checksum so the verdict stays true
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      chk_ok <= 1'b1;
    end else begin
      chk_ok <= 1'b1;
      if (word_cnt == DEPTH_A) done <= 1'b1;
    end
  end
`endif

endmodule
